// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, default depth, statistics counter width
//               and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      ACK   = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam int DEFAULT_DEPTH = 1024;
   localparam int STAT_W        = 16;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter. Produces a one-hot grant from
//               the request pair and remembers which port was granted last;
//               the pointer only moves when grant_en accepts a grant.
//               Out of reset port 0 is favoured.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] gnt
);

   // last_q = 1 means port 1 was granted last, so port 0 wins a tie.
   logic last_q;
   logic last_d;

   // One-hot grant: a lone requester wins, a tie goes to the port not granted last.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer follows every accepted grant, including error grants.
   always_comb begin
      last_d = last_q;
      if (grant_en && (|req)) begin
         last_d = gnt[1];
      end
   end

   // Pointer register; reset leaves port 0 favoured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port registered-output data memory between
//               requester 0 (CPU) and requester 1 (DMA/debug). One
//               transaction in flight, round-robin on ties, error ack for
//               word addresses >= DEPTH without touching the memory.
//               All outputs are registered.
//               Optional build macro DMEM_ARB_STATS_EN adds saturating
//               grant and conflict counters on stat_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic              r0_err,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic              r1_err,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_grant0,
   output logic [STAT_W-1:0] stat_grant1,
   output logic [STAT_W-1:0] stat_conflict
`endif
);

   // Full address compared, so stray upper bits are reported as errors.
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

   state_t            state_q, state_d;
   logic              win_q, win_d;        // port owning the transaction
   logic              we_q, we_d;          // latched direction
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              grant_en;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req = {r1_req, r0_req};

   rr_arbiter_2 u_rr (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .grant_en (grant_en),
      .gnt      (gnt)
   );

   // Command of whichever port the arbiter picks this cycle.
   always_comb begin
      sel_we    = gnt[1] ? r1_we    : r0_we;
      sel_addr  = gnt[1] ? r1_addr  : r0_addr;
      sel_wdata = gnt[1] ? r1_wdata : r0_wdata;
   end

   // Next-state and next-output logic; strobes and acks default low so each is a single-cycle pulse.
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rdata_d[0]  = rdata_q[0];
      rdata_d[1]  = rdata_q[1];
      grant_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_en = 1'b1;
               win_d    = gnt[1];
               we_d     = sel_we;
               if (sel_addr >= ADDR_LIMIT) begin
                  // Rejected: acknowledge with error next cycle, memory untouched.
                  state_d       = ERR;
                  ack_d[gnt[1]] = 1'b1;
                  err_d[gnt[1]] = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  mem_read_d  = ~sel_we;
                  mem_write_d = sel_we;
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = sel_wdata;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d       = ACK;
               ack_d[win_q]  = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Memory output is valid now, one cycle after the read strobe.
            rdata_d[win_q] = mem_rdata;
            ack_d[win_q]   = 1'b1;
            state_d        = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset abandons any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata_q[0]  <= '0;
         rdata_q[1]  <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q[0]  <= rdata_d[0];
         rdata_q[1]  <= rdata_d[1];
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign r0_ack    = ack_q[0];
   assign r1_ack    = ack_q[1];
   assign r0_err    = err_q[0];
   assign r1_err    = err_q[1];
   assign r0_rdata  = rdata_q[0];
   assign r1_rdata  = rdata_q[1];

`ifdef DMEM_ARB_STATS_EN
   logic [STAT_W-1:0] grant0_q, grant0_d;
   logic [STAT_W-1:0] grant1_q, grant1_d;
   logic [STAT_W-1:0] conflict_q, conflict_d;

   // Count accepted grants per port and idle cycles where both ports contend.
   always_comb begin
      grant0_d   = grant0_q;
      grant1_d   = grant1_q;
      conflict_d = conflict_q;
      if (grant_en && gnt[0]) begin
         grant0_d = sat_inc(grant0_q);
      end
      if (grant_en && gnt[1]) begin
         grant1_d = sat_inc(grant1_q);
      end
      if ((state_q == IDLE) && (&req)) begin
         conflict_d = sat_inc(conflict_q);
      end
   end

   // Statistics registers, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant0_q   <= '0;
         grant1_q   <= '0;
         conflict_q <= '0;
      end else begin
         grant0_q   <= grant0_d;
         grant1_q   <= grant1_d;
         conflict_q <= conflict_d;
      end
   end

   assign stat_grant0   = grant0_q;
   assign stat_grant1   = grant1_q;
   assign stat_conflict = conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter paired with a
//               behavioural 1024-word registered-output data memory.
//               Build with DMEM_ARB_STATS_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              r0_req = 0, r0_we = 0;
   logic [ADDR_W-1:0] r0_addr = '0;
   logic [DATA_W-1:0] r0_wdata = '0;
   logic              r1_req = 0, r1_we = 0;
   logic [ADDR_W-1:0] r1_addr = '0;
   logic [DATA_W-1:0] r1_wdata = '0;
   logic              r0_ack, r0_err, r1_ack, r1_err;
   logic [DATA_W-1:0] r0_rdata, r1_rdata;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
   logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_ack    (r0_ack),
      .r0_err    (r0_err),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_ack    (r1_ack),
      .r1_err    (r1_err),
      .r1_rdata  (r1_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_grant0   (stat_grant0),
      .stat_grant1   (stat_grant1),
      .stat_conflict (stat_conflict)
`endif
   );

   // Behavioural data_memory: synchronous reset of the output register, registered read.
   always @(posedge clk) begin
      if (reset) begin
         mem_rdata <= '0;
      end else begin
         if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem[mem_addr[9:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mutual-exclusion invariants checked every cycle out of reset.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
         chk("ack_exclusive", 64'(r0_ack & r1_ack), 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd);
      if (p == 0) begin
         r0_req = v; r0_we = we; r0_addr = addr; r0_wdata = wd;
      end else begin
         r1_req = v; r1_we = we; r1_addr = addr; r1_wdata = wd;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) r0_req = 1'b0;
      else        r1_req = 1'b0;
   endtask

   // Next edge is the grant edge for port p; checks strobes, exact ack latency, err and rdata.
   task automatic run(input string tag, input int p, input int lat, input logic we,
                      input logic [31:0] addr, input logic exp_err,
                      input logic [31:0] exp_rd, input logic do_drop);
      logic [1:0] ack;
      logic [1:0] err;
      logic [31:0] rd;
      for (int c = 1; c <= lat; c++) begin
         step();
         ack = {r1_ack, r0_ack};
         err = {r1_err, r0_err};
         rd  = (p == 0) ? r0_rdata : r1_rdata;
         if (c == 1) begin
            if (exp_err) begin
               chk({tag, "_strobes"}, 64'({mem_read, mem_write}), 64'd0);
            end else begin
               chk({tag, "_strobes"}, 64'({mem_read, mem_write}), 64'({~we, we}));
               chk({tag, "_maddr"}, 64'(mem_addr), 64'(addr));
            end
         end
         chk({tag, "_ack"}, 64'(ack), (c == lat) ? 64'(2'b01 << p) : 64'd0);
         if (c == lat) begin
            chk({tag, "_err"}, 64'(err[p]), 64'(exp_err));
            if (!we) chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
            if (do_drop) drop(p);
         end
      end
      // ACK/ERR cycle ends: back in IDLE with acks low.
      step();
      chk({tag, "_ackdone"}, 64'({r1_ack, r0_ack}), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 64'({r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write}), 64'd0);
      chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_rd0"}, 64'(r0_rdata), 64'd0);
      chk({tag, "_rd1"}, 64'(r1_rdata), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk_all_zero("reset");
      step();

      // Write then read back on port 0: latencies 2 and 3.
      set_req(0, 1, 1, 32'd5, 32'hDEADBEEF);
      run("t1_wr", 0, 2, 1'b1, 32'd5, 1'b0, 32'h0, 1'b1);
      chk("t1_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      set_req(0, 1, 0, 32'd5, 32'h0);
      run("t1_rd", 0, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b1);

      // Port 1 valid read, then out-of-range read: error ack, rdata held.
      set_req(1, 1, 0, 32'd5, 32'h0);
      run("t3_rd", 1, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b1);
      set_req(1, 1, 0, 32'd1024, 32'h0);
      run("t3_err", 1, 1, 1'b0, 32'd1024, 1'b1, 32'hDEADBEEF, 1'b1);
      chk("t3_quiet", 64'({mem_read, mem_write}), 64'd0);

      // Simultaneous reads; port 1 was granted last, so port 0 goes first.
      set_req(0, 1, 0, 32'd5, 32'h0);
      set_req(1, 1, 0, 32'd1023, 32'h0);
      run("t2a_p0", 0, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b1);
      run("t2a_p1", 1, 3, 1'b0, 32'd1023, 1'b0, 32'h0, 1'b1);

      // Port 0 drops req during ISSUE of a write: write lands, one ack, no regrant.
      set_req(0, 1, 1, 32'd9, 32'h12345678);
      step();
      chk("t5_issue", 64'({mem_read, mem_write}), 64'b01);
      drop(0);
      step();
      chk("t5_ack", 64'({r1_ack, r0_ack}), 64'b01);
      step();
      chk("t5_ackdone", 64'({r1_ack, r0_ack}), 64'd0);
      step();
      chk("t5_nogrant", 64'({mem_read, mem_write, r1_ack, r0_ack}), 64'd0);
      step();
      chk("t5_nogrant2", 64'({mem_read, mem_write, r1_ack, r0_ack}), 64'd0);
      chk("t5_mem", 64'(mem[9]), 64'h12345678);

      // Second simultaneous pair; port 0 was granted last, so port 1 goes first.
      set_req(0, 1, 0, 32'd1023, 32'h0);
      set_req(1, 1, 0, 32'd9, 32'h0);
      run("t2b_p1", 1, 3, 1'b0, 32'd9, 1'b0, 32'h12345678, 1'b1);
      run("t2b_p0", 0, 3, 1'b0, 32'd1023, 1'b0, 32'h0, 1'b1);

      // Reset in WAIT of a read at addr 7, then a fresh read returns the stored value.
      set_req(1, 1, 1, 32'd7, 32'hA5A50007);
      run("t4_wr", 1, 2, 1'b1, 32'd7, 1'b0, 32'h0, 1'b1);
      set_req(0, 1, 0, 32'd7, 32'h0);
      step();
      chk("t4_issue", 64'(mem_read), 64'd1);
      step();
      chk("t4_wait", 64'({mem_read, r0_ack}), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("t4_async");
      drop(0);
      step();
      step();
      reset = 1'b0;
      step();
      chk_all_zero("t4_post");
      set_req(0, 1, 0, 32'd7, 32'h0);
      run("t4_rd", 0, 3, 1'b0, 32'd7, 1'b0, 32'hA5A50007, 1'b1);

`ifdef DMEM_ARB_STATS_EN
      // Counters: both ports held through four alternating grants, then port 0 alone.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("t6_g0_rst", 64'(stat_grant0), 64'd0);
      chk("t6_g1_rst", 64'(stat_grant1), 64'd0);
      chk("t6_cf_rst", 64'(stat_conflict), 64'd0);
      set_req(0, 1, 0, 32'd5, 32'h0);
      set_req(1, 1, 0, 32'd5, 32'h0);
      run("t6_a", 0, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b0);
      run("t6_b", 1, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b0);
      run("t6_c", 0, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b0);
      run("t6_d", 1, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b1);
      run("t6_e", 0, 3, 1'b0, 32'd5, 1'b0, 32'hDEADBEEF, 1'b1);
      chk("t6_g0", 64'(stat_grant0), 64'd3);
      chk("t6_g1", 64'(stat_grant1), 64'd2);
      chk("t6_cf", 64'(stat_conflict), 64'd4);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
